axis_id_packing_mux: RTL
========================

// Module: axis_id_packing_mux
// PURPOSE
//  Frame-level round-robin merge of NUM_PORTS AXI-S inputs into one stream.
//  Tags each frame with its source port as TID and packs {TID, TKEEP} into TUSER.
//  Feeds TID-less infrastructure (FIFOs, CDC, width converters) directly upstream of axis_id_unpacker.
//  Frames are never interleaved: a grant holds from first beat to TLAST.
// PARAMETERS
//  NUM_PORTS    4                          number of input streams, 2..2**TID_WIDTH
//  DATA_WIDTH   8                          tdata width per port, multiple of 8
//  TID_WIDTH    2                          TID width; NUM_PORTS <= 2**TID_WIDTH
//  TUSER_WIDTH  TID_WIDTH+DATA_WIDTH/8     packed sideband width
// PORTS
//  aclk           in   1                       clock, all logic on rising edge
//  aresetn        in   1                       synchronous reset, active-low
//  s_axis_tdata   in   NUM_PORTS*DATA_WIDTH    port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_axis_tkeep   in   NUM_PORTS*DATA_WIDTH/8  port i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//  s_axis_tlast   in   NUM_PORTS               per-port tlast
//  s_axis_tvalid  in   NUM_PORTS               per-port tvalid
//  s_axis_tready  out  NUM_PORTS               per-port tready
//  m_axis_tdata   out  DATA_WIDTH              merged data
//  m_axis_tlast   out  1                       merged tlast
//  m_axis_tvalid  out  1                       merged tvalid
//  m_axis_tuser   out  TUSER_WIDTH             {tid[TID_WIDTH-1:0], tkeep[DATA_WIDTH/8-1:0]}, tid in MSBs
//  m_axis_tready  in   1                       downstream ready
// BEHAVIOUR
//  - Reset (aresetn=0 at edge): state=IDLE, grant=0, last_grant=NUM_PORTS-1 (port 0 wins first);
//    m_axis_tvalid=0, s_axis_tready=0 for all ports, any output register emptied.
//  - FSM IDLE: if any s_axis_tvalid, grant <= first valid port searching last_grant+1 upward, wrap
//    at NUM_PORTS-1 -> 0; go LOCKED. No valid: stay IDLE. One bubble cycle per frame.
//  - FSM LOCKED: output path = granted port; s_axis_tready[grant]=m-side ready, all others 0.
//    Beat accepted when tvalid&tready on granted port. Accepted beat with tlast: last_grant<=grant, go IDLE.
//  - Granted port deasserting tvalid mid-frame: grant held, m_axis_tvalid=0; no other port served.
//  - Single-beat frame (tlast on first beat): legal, one beat then IDLE.
//  - Ports not granted see tready=0 and must hold data (AXI-S rules); never dropped.
//  - m_axis_tuser tid field = grant zero-extended to TID_WIDTH; tkeep passed unmodified.
//  - tvalid must not depend on tready; once m_axis_tvalid=1, data/last/user stable until accepted.
//  - Reset mid-frame: frame abandoned, downstream sees a truncated frame without tlast; documented,
//    no recovery logic. Source ports are reset with this block.
//  - Starvation bound: a waiting port is granted within NUM_PORTS-1 frames.
// CONFIGURATION
//  AXIS_ID_PACKING_MUX_REG_OUT_EN defined: 2-entry skid buffer on m_axis_*; +1 cycle latency,
//    full throughput, s_axis_tready registered (no combinational m_axis_tready -> s_axis_tready path).
//  Undefined: m_axis_* combinational from granted port in LOCKED; zero added latency;
//    s_axis_tready[grant] = m_axis_tready combinationally.
// STRUCTURE
//  Shared package/header axis_id_defs: TUSER layout localparams (TUSER_KEEP_LSB=0,
//    TUSER_TID_LSB=DATA_WIDTH/8), FSM state encodings IDLE=0/LOCKED=1; also used by axis_id_unpacker.
//  Sub-module axis_skid_buffer (WIDTH=DATA_WIDTH+1+TUSER_WIDTH), instantiated only under REG_OUT_EN.
//  Round-robin search is a combinational for-loop in this module; no separate arbiter.
// TESTING (run with and without AXIS_ID_PACKING_MUX_REG_OUT_EN)
//  1. Reset: aresetn=0 3 cycles, all inputs valid -> m_axis_tvalid=0, s_axis_tready=4'b0000 throughout.
//  2. Ports 0..3 each 3-beat frame, m_axis_tready=1 -> order 0,1,2,3; tuser tid 0,1,2,3; no interleave.
//  3. Only port 2 valid, 4-beat frame, tkeep last=1'b1 -> 4 beats, m_axis_tuser={2'd2,1'b1}, tlast on beat 4.
//  4. Port 1 mid-frame drops tvalid 5 cycles while port 3 valid -> port 3 tready stays 0, port 1 frame completes first.
//  5. m_axis_tready random 50% on frames from all ports -> scoreboard per-TID data/keep/last exact, no loss/dup.
//  6. aresetn pulsed during beat 2 of port 0 frame -> after release port 0 granted first, last_grant=3 behaviour.

Source files
------------

// File: rtl/axis_id_packing_mux_pkg.sv
// Shared definitions for the AXI-S ID packing mux: TUSER layout and FSM encoding.
// The optional output register stage is AXIS_ID_PACKING_MUX_REG_OUT_EN (see axis_id_packing_mux.sv).
package axis_id_packing_mux_pkg;

    // TUSER = {tid, tkeep}; keep in the LSBs, tid directly above it.
    localparam int TUSER_KEEP_LSB = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int tuser_tid_lsb(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int tuser_width(input int tid_width, input int data_width);
        return tid_width + data_width / 8;
    endfunction

endpackage

// File: rtl/axis_id_packing_mux_if.sv
// Bundle of all stream signals around the ID packing mux: NUM_PORTS input streams plus one merged output.
// Handshake: a beat transfers on a rising edge where tvalid&tready; tvalid never waits on tready, and a
// source holds data/keep/last/user stable from tvalid=1 until the transfer happens.
interface axis_id_packing_mux_if
    import axis_id_packing_mux_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TID_WIDTH  = 2
);
    localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
    localparam int TUSER_WIDTH = tuser_width(TID_WIDTH, DATA_WIDTH);

    logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [NUM_PORTS-1:0]            s_axis_tlast;
    logic [NUM_PORTS-1:0]            s_axis_tvalid;
    logic [NUM_PORTS-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic                            m_axis_tlast;
    logic                            m_axis_tvalid;
    logic [TUSER_WIDTH-1:0]          m_axis_tuser;
    logic                            m_axis_tready;

    // The mux side: consumes the input streams and drives the merged stream.
    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tuser
    );

    // The environment side: sources and sink around the mux.
    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tuser
    );

endinterface

// File: rtl/axis_id_packing_mux_skid_buffer.sv
// Two-entry skid buffer: registered output and registered s_ready, full throughput.
// Used by axis_id_packing_mux only when AXIS_ID_PACKING_MUX_REG_OUT_EN is defined.
module axis_id_packing_mux_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Ready only reflects whether the spare slot is free, so it never depends on m_ready this cycle.
    assign s_ready = ~skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!m_valid || m_ready) begin
            if (skid_valid) begin
                m_data     <= skid_data;
                m_valid    <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= s_valid;
                if (s_valid) begin
                    m_data <= s_data;
                end
            end
        end else if (s_valid && s_ready) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_id_packing_mux.sv
// Frame-level round-robin merge of NUM_PORTS AXI-S inputs; source port travels as TID packed into TUSER.
// Define AXIS_ID_PACKING_MUX_REG_OUT_EN to register the merged output through a skid buffer.
module axis_id_packing_mux
    import axis_id_packing_mux_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TID_WIDTH  = 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axis_id_packing_mux_if.master  bus,
    output state_t                 dbg_state
);
    localparam int KEEP_WIDTH    = DATA_WIDTH / 8;
    localparam int TUSER_WIDTH   = tuser_width(TID_WIDTH, DATA_WIDTH);
    localparam int TID_LSB       = tuser_tid_lsb(DATA_WIDTH);
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + 1 + TUSER_WIDTH;
    localparam logic [TID_WIDTH-1:0] LAST_PORT = TID_WIDTH'(NUM_PORTS - 1);

    state_t                 state;
    logic [TID_WIDTH-1:0]   grant;
    logic [TID_WIDTH-1:0]   last_grant;
    logic [TID_WIDTH-1:0]   rr_next;
    logic [TID_WIDTH-1:0]   hi_idx;
    logic [TID_WIDTH-1:0]   lo_idx;
    logic                   hi_hit;
    logic                   port_valid;
    logic                   port_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;
    logic [TUSER_WIDTH-1:0] sel_user;
    logic                   sel_valid;
    logic                   up_ready;
    logic                   beat_acc;

    // Round robin: lowest valid port above last_grant, else lowest valid port overall (wrap).
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.s_axis_tvalid[i]) begin
                lo_idx = TID_WIDTH'(i);
                if (TID_WIDTH'(i) > last_grant) begin
                    hi_hit = 1'b1;
                    hi_idx = TID_WIDTH'(i);
                end
            end
        end
        rr_next = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        port_valid = 1'b0;
        port_last  = 1'b0;
        sel_data   = '0;
        sel_keep   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == TID_WIDTH'(i)) begin
                port_valid = bus.s_axis_tvalid[i];
                port_last  = bus.s_axis_tlast[i];
                sel_data   = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep   = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    always_comb begin
        sel_user                                = '0;
        sel_user[TID_LSB +: TID_WIDTH]          = grant;
        sel_user[TUSER_KEEP_LSB +: KEEP_WIDTH]  = sel_keep;
    end

    assign sel_valid = (state == LOCKED) && port_valid;
    assign beat_acc  = sel_valid && up_ready;

    // Only the granted port ever sees ready; everyone else holds its beat.
    always_comb begin
        bus.s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.s_axis_tready[i] = (state == LOCKED) && (grant == TID_WIDTH'(i)) && up_ready;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_PORT;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.s_axis_tvalid) begin
                        grant <= rr_next;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (beat_acc && port_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

`ifdef AXIS_ID_PACKING_MUX_REG_OUT_EN
    logic [PAYLOAD_WIDTH-1:0] out_payload;

    axis_id_packing_mux_skid_buffer #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_valid (sel_valid),
        .s_ready (up_ready),
        .s_data  ({port_last, sel_user, sel_data}),
        .m_valid (bus.m_axis_tvalid),
        .m_ready (bus.m_axis_tready),
        .m_data  (out_payload)
    );

    assign bus.m_axis_tlast = out_payload[PAYLOAD_WIDTH-1];
    assign bus.m_axis_tuser = out_payload[DATA_WIDTH +: TUSER_WIDTH];
    assign bus.m_axis_tdata = out_payload[DATA_WIDTH-1:0];
`else
    assign up_ready          = bus.m_axis_tready;
    assign bus.m_axis_tvalid = sel_valid;
    assign bus.m_axis_tlast  = port_last;
    assign bus.m_axis_tuser  = sel_user;
    assign bus.m_axis_tdata  = sel_data;
`endif

endmodule
